// File: rtl/hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
// The datapath side drives decode/resolve status; the controller drives stage enables, forwarding selects and counters.
interface hazard_ctrl_if #(
  parameter int PERF_W = 32
);
  logic              id_valid;
  logic [9:0]        id_optype;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic              ex_br_taken;
  logic              dmem_ready;
  logic              pc_we;
  logic              ifid_we;
  logic              ifid_flush;
  logic              idex_we;
  logic              idex_flush;
  logic              exmem_we;
  logic              memwb_we;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [PERF_W-1:0] cnt_lduse;
  logic [PERF_W-1:0] cnt_memwait;
  logic [PERF_W-1:0] cnt_flush;

  modport master (
    output id_valid, id_optype, id_rs1, id_rs2, id_rd, ex_br_taken, dmem_ready,
    input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we,
    input  fwd_a, fwd_b, cnt_lduse, cnt_memwait, cnt_flush
  );

  modport slave (
    input  id_valid, id_optype, id_rs1, id_rs2, id_rd, ex_br_taken, dmem_ready,
    output pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, memwb_we,
    output fwd_a, fwd_b, cnt_lduse, cnt_memwait, cnt_flush
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline sequencing: stage enables, flushes, load-use bubbles,
// memory-wait freezes and EX operand forwarding, from shadow copies of EX/MEM/WB metadata.
module hazard_ctrl #(
  parameter int PERF_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       use1;
    logic       use2;
    logic       regwen;
    logic       load;
    logic       memop;
  } meta_t;

  function automatic meta_t decode(input logic [9:0] op, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [4:0] rd);
    meta_t m;
    m.rs1    = rs1;
    m.rs2    = rs2;
    m.rd     = rd;
    m.use1   = op[0] | op[1] | op[2] | op[3] | op[5] | op[6];
    m.use2   = op[0] | op[5] | op[6];
    m.regwen = op[0] | op[1] | op[2] | op[3] | op[7] | op[8] | op[9];
    m.load   = op[2];
    m.memop  = op[2] | op[5];
    return m;
  endfunction

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + {{(PERF_W-1){1'b0}}, 1'b1};
  endfunction

  // MEM beats WB; a load sitting in MEM has no result yet and is never a source.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] rs,
                                         input logic mem_vld, input meta_t mem,
                                         input logic wb_vld, input meta_t wb);
    if (!used || rs == 5'd0)                                  return 2'b00;
    if (mem_vld && mem.regwen && !mem.load && mem.rd == rs)   return 2'b10;
    if (wb_vld && wb.regwen && wb.rd == rs)                   return 2'b01;
    return 2'b00;
  endfunction

  logic              r_ex_vld, r_mem_vld, r_wb_vld;
  meta_t             r_ex, r_mem, r_wb;
  logic [PERF_W-1:0] r_cnt_lduse, r_cnt_memwait, r_cnt_flush;

  meta_t w_id;
  logic  w_memwait, w_redirect, w_lduse, w_hit1, w_hit2;

  assign w_id       = decode(bus.id_optype, bus.id_rs1, bus.id_rs2, bus.id_rd);
  assign w_memwait  = r_mem_vld & r_mem.memop & ~bus.dmem_ready;
  assign w_redirect = ~w_memwait & r_ex_vld & bus.ex_br_taken;
  assign w_hit1     = w_id.use1 & (bus.id_rs1 == r_ex.rd);
  assign w_hit2     = w_id.use2 & (bus.id_rs2 == r_ex.rd);
  assign w_lduse    = ~w_memwait & ~w_redirect & r_ex_vld & r_ex.load &
                      (r_ex.rd != 5'd0) & bus.id_valid & (w_hit1 | w_hit2);

  assign bus.pc_we       = ~w_memwait & ~w_lduse;
  assign bus.ifid_we     = ~w_memwait & ~w_lduse;
  assign bus.ifid_flush  = w_redirect;
  assign bus.idex_we     = ~w_memwait;
  assign bus.idex_flush  = w_redirect | w_lduse;
  assign bus.exmem_we    = ~w_memwait;
  assign bus.memwb_we    = ~w_memwait;

  // A bubble in EX has no operands to forward.
  assign bus.fwd_a = r_ex_vld ? fwd_sel(r_ex.use1, r_ex.rs1, r_mem_vld, r_mem, r_wb_vld, r_wb) : 2'b00;
  assign bus.fwd_b = r_ex_vld ? fwd_sel(r_ex.use2, r_ex.rs2, r_mem_vld, r_mem, r_wb_vld, r_wb) : 2'b00;

  assign bus.cnt_lduse   = r_cnt_lduse;
  assign bus.cnt_memwait = r_cnt_memwait;
  assign bus.cnt_flush   = r_cnt_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_vld      <= 1'b0;
      r_mem_vld     <= 1'b0;
      r_wb_vld      <= 1'b0;
      r_cnt_lduse   <= '0;
      r_cnt_memwait <= '0;
      r_cnt_flush   <= '0;
    end else begin
      if (!w_memwait) begin
        r_wb_vld  <= r_mem_vld;
        r_mem_vld <= r_ex_vld;
        r_ex_vld  <= bus.id_valid & ~w_redirect & ~w_lduse;
      end
      if (w_memwait)  r_cnt_memwait <= sat_inc(r_cnt_memwait);
      if (w_redirect) r_cnt_flush   <= sat_inc(r_cnt_flush);
      if (w_lduse)    r_cnt_lduse   <= sat_inc(r_cnt_lduse);
    end
  end

  // Metadata is only meaningful under its valid bit, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!w_memwait) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_id;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic against an
// instruction-level pipeline model.
module tb_hazard_ctrl;
  localparam int PERF_W = 3;
  localparam int CAP    = (1 << PERF_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.PERF_W(PERF_W)) bus ();
  hazard_ctrl #(.PERF_W(PERF_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { bit v; int k; int rs1; int rs2; int rd; } ins_t;

  ins_t m_ex, m_mem, m_wb;
  int   m_lu, m_mw, m_fl;
  int   n_chk = 0, n_err = 0;
  bit   cur_v, cur_br, cur_rdy;
  int   cur_k, cur_rs1, cur_rs2, cur_rd;

  // Instruction classes: 0 R, 1 I, 2 load, 3 JALR, 4 system, 5 S, 6 B, 7 LUI, 8 AUIPC, 9 JAL
  function automatic bit reads1(int k);  return k inside {0, 1, 2, 3, 5, 6};    endfunction
  function automatic bit reads2(int k);  return k inside {0, 5, 6};             endfunction
  function automatic bit writes(int k);  return k inside {0, 1, 2, 3, 7, 8, 9}; endfunction
  function automatic bit is_mem(int k);  return k == 2 || k == 5;               endfunction

  function automatic int src_of(int rs, bit used);
    if (!used || rs == 0) return 0;
    if (m_mem.v && writes(m_mem.k) && m_mem.k != 2 && m_mem.rd == rs) return 2;
    if (m_wb.v && writes(m_wb.k) && m_wb.rd == rs) return 1;
    return 0;
  endfunction

  function automatic int bump(int c); return (c < CAP) ? c + 1 : c; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input int k, input int rs1, input int rs2, input int rd,
                       input bit br, input bit rdy);
    @(negedge clk);
    cur_v = v; cur_k = k; cur_rs1 = rs1; cur_rs2 = rs2; cur_rd = rd; cur_br = br; cur_rdy = rdy;
    bus.id_valid    = v;
    bus.id_optype   = 10'd1 << k;
    bus.id_rs1      = 5'(rs1);
    bus.id_rs2      = 5'(rs2);
    bus.id_rd       = 5'(rd);
    bus.ex_br_taken = br;
    bus.dmem_ready  = rdy;
    #1;
  endtask

  task automatic cycle();
    bit wt, rdr, lu;
    wt  = m_mem.v && is_mem(m_mem.k) && !cur_rdy;
    rdr = !wt && m_ex.v && cur_br;
    lu  = !wt && !rdr && m_ex.v && m_ex.k == 2 && m_ex.rd != 0 && cur_v &&
          ((reads1(cur_k) && cur_rs1 == m_ex.rd) || (reads2(cur_k) && cur_rs2 == m_ex.rd));
    chk("pc_we",      bus.pc_we,      !(wt || lu));
    chk("ifid_we",    bus.ifid_we,    !(wt || lu));
    chk("ifid_flush", bus.ifid_flush, rdr);
    chk("idex_we",    bus.idex_we,    !wt);
    chk("idex_flush", bus.idex_flush, rdr || lu);
    chk("exmem_we",   bus.exmem_we,   !wt);
    chk("memwb_we",   bus.memwb_we,   !wt);
    if (m_ex.v) begin
      chk("fwd_a", bus.fwd_a, src_of(m_ex.rs1, reads1(m_ex.k)));
      chk("fwd_b", bus.fwd_b, src_of(m_ex.rs2, reads2(m_ex.k)));
    end
    chk("cnt_lduse",   bus.cnt_lduse,   m_lu);
    chk("cnt_memwait", bus.cnt_memwait, m_mw);
    chk("cnt_flush",   bus.cnt_flush,   m_fl);
    if (wt) m_mw = bump(m_mw);
    if (rdr) m_fl = bump(m_fl);
    if (lu) m_lu = bump(m_lu);
    if (!wt) begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = '{v: cur_v && !rdr && !lu, k: cur_k, rs1: cur_rs1, rs2: cur_rs2, rd: cur_rd};
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    m_ex.v = 0; m_mem.v = 0; m_wb.v = 0;
    m_lu = 0; m_mw = 0; m_fl = 0;
    bus.id_valid = 1'b0; bus.ex_br_taken = 1'b0; bus.dmem_ready = 1'b1;
    cur_v = 0; cur_br = 0; cur_rdy = 1;
    chk("rst_pc_we",   bus.pc_we,    1);
    chk("rst_idex_we", bus.idex_we,  1);
    chk("rst_memwb",   bus.memwb_we, 1);
    chk("rst_flush",   {bus.ifid_flush, bus.idex_flush}, 0);
    chk("rst_fwd",     {bus.fwd_a, bus.fwd_b}, 0);
    chk("rst_cnt",     {bus.cnt_lduse, bus.cnt_memwait, bus.cnt_flush}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.id_optype = 10'd1; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
    do_reset();

    // Back-to-back ALU dependencies: MEM then WB forwarding
    drive(1, 0, 1, 2, 5, 0, 1); cycle();
    drive(1, 0, 5, 5, 6, 0, 1); cycle();
    drive(1, 0, 5, 5, 7, 0, 1);
    chk("b2b_fwd_a_mem", bus.fwd_a, 2'b10);
    chk("b2b_fwd_b_mem", bus.fwd_b, 2'b10);
    chk("b2b_no_stall", bus.pc_we, 1);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("b2b_fwd_a_wb", bus.fwd_a, 2'b01);
    cycle();

    // Load-use: one bubble, then WB forwarding
    do_reset();
    drive(1, 2, 1, 0, 7, 0, 1); cycle();
    drive(1, 0, 7, 1, 8, 0, 1);
    chk("lu_pc_we", bus.pc_we, 0);
    chk("lu_ifid_we", bus.ifid_we, 0);
    chk("lu_idex_flush", bus.idex_flush, 1);
    cycle();
    drive(1, 0, 7, 1, 8, 0, 1);
    chk("lu_once", bus.pc_we, 1);
    chk("lu_cnt", bus.cnt_lduse, 1);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("lu_fwd_wb", bus.fwd_a, 2'b01);
    cycle();

    // Redirect wins over load-use
    do_reset();
    drive(1, 2, 1, 0, 7, 0, 1); cycle();
    drive(1, 0, 7, 1, 8, 1, 1);
    chk("rd_ifid_flush", bus.ifid_flush, 1);
    chk("rd_idex_flush", bus.idex_flush, 1);
    chk("rd_pc_we", bus.pc_we, 1);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("rd_cnt_flush", bus.cnt_flush, 1);
    chk("rd_cnt_lduse", bus.cnt_lduse, 0);
    cycle();

    // Store waiting in MEM freezes everything, pending redirect taken once
    do_reset();
    drive(1, 5, 1, 2, 0, 0, 1); cycle();
    drive(1, 6, 3, 4, 0, 0, 1); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 1, 9, 1, 0);
      chk("mw_frozen", {bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we, bus.memwb_we}, 0);
      chk("mw_noflush", {bus.ifid_flush, bus.idex_flush}, 0);
      cycle();
    end
    drive(1, 0, 1, 1, 9, 1, 1);
    chk("mw_cnt", bus.cnt_memwait, 3);
    chk("mw_redirect", bus.ifid_flush, 1);
    cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("mw_flush_once", bus.cnt_flush, 1);
    cycle();

    // x0 destinations never stall or forward
    do_reset();
    drive(1, 2, 1, 0, 0, 0, 1); cycle();
    drive(1, 0, 0, 0, 8, 0, 1);
    chk("x0_no_stall", bus.pc_we, 1);
    cycle();
    drive(1, 0, 1, 2, 0, 0, 1);
    chk("x0_fwd_load", {bus.fwd_a, bus.fwd_b}, 0);
    cycle();
    drive(1, 0, 0, 0, 3, 0, 1); cycle();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("x0_fwd_alu", {bus.fwd_a, bus.fwd_b}, 0);
    cycle();

    // Reset asserted in the middle of a memory wait
    do_reset();
    drive(1, 5, 1, 2, 0, 0, 1); cycle();
    drive(1, 0, 1, 2, 1, 0, 1); cycle();
    drive(1, 0, 1, 1, 4, 0, 0); cycle();
    drive(1, 0, 1, 1, 4, 0, 0);
    chk("mwr_frozen", bus.pc_we, 0);
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("mwr_we", bus.pc_we, 1);
    chk("mwr_fwd", {bus.fwd_a, bus.fwd_b}, 0);
    cycle();

    // Randomized traffic; small counters exercise saturation
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(9, 0) < 8, $urandom_range(9, 0), $urandom_range(3, 0),
            $urandom_range(3, 0), $urandom_range(3, 0),
            $urandom_range(99, 0) < 15, $urandom_range(99, 0) < 70);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
